// File: rtl/register_file_2r1w.sv
// Two-read, one-write register file that sits between decode and the ALU
// operand muxes. Both read ports are registered (one cycle latency) and
// forward a same-cycle write. Port A can instead return its address field as
// an immediate operand. An optional hard-wired zero register is supported.
// After reset, a clear sweep zeroes every entry one per cycle before ready
// rises.
module register_file_2r1w #(
  parameter int DATA_WIDTH     = 8,
  parameter int POINTER_WIDTH  = 3,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit ZERO_REG       = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [POINTER_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [POINTER_WIDTH-1:0] read_address_a,
  input  logic                     is_immediate_a,
  input  logic [POINTER_WIDTH-1:0] read_address_b,
  output logic [DATA_WIDTH-1:0]    read_data_a,
  output logic [DATA_WIDTH-1:0]    read_data_b,
  output logic                     ready
);

  localparam int DEPTH = 2 ** POINTER_WIDTH;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                   state;
  logic [POINTER_WIDTH-1:0] clear_ptr;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic                     write_allowed;
  logic                     mem_we;
  logic [POINTER_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    immediate_a;
  logic [DATA_WIDTH-1:0]    next_a;
  logic [DATA_WIDTH-1:0]    next_b;

  // Immediate operand: the port A address field, zero-extended or truncated
  // to the data width.
  generate
    if (POINTER_WIDTH >= DATA_WIDTH) begin : g_imm_trunc
      assign immediate_a = read_address_a[DATA_WIDTH-1:0];
    end else begin : g_imm_ext
      assign immediate_a = {{(DATA_WIDTH - POINTER_WIDTH){1'b0}}, read_address_a};
    end
  endgenerate

  // An external write only counts when it targets a writable register.
  assign write_allowed = write_enable && !(ZERO_REG && (write_address == '0));

  // Select the single storage write port: clear sweep in CLEAR, external
  // write in RUN, nothing while reset is held.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    mem_we    = 1'b0;
    mem_waddr = clear_ptr;
    mem_wdata = '0;
    if (!reset) begin
      unique case (state)
        CLEAR: mem_we = 1'b1;
        RUN: begin
          if (write_allowed) begin
            mem_we    = 1'b1;
            mem_waddr = write_address;
            mem_wdata = write_data;
          end
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  // Next read values: array lookup, then write-through bypass, then the
  // zero-register mask, then (port A only) the immediate override.
  always_comb begin
    next_a = mem[read_address_a];
    if (write_allowed && (write_address == read_address_a)) next_a = write_data;
    if (ZERO_REG && (read_address_a == '0)) next_a = '0;
    if (is_immediate_a) next_a = immediate_a;

    next_b = mem[read_address_b];
    if (write_allowed && (write_address == read_address_b)) next_b = write_data;
    if (ZERO_REG && (read_address_b == '0)) next_b = '0;
  end

  // Storage array update.
  always_ff @(posedge clock) begin
    // NOTE: the array itself has no reset term; zeroing is done by the clear
    // sweep so the storage can map onto plain RAM cells.
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control FSM, clear pointer and registered read outputs.
  always_ff @(posedge clock) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= CLEAR_ON_RESET ? CLEAR : RUN;
      clear_ptr   <= '0;
      ready       <= 1'b0;
      read_data_a <= '0;
      read_data_b <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          clear_ptr   <= clear_ptr + POINTER_WIDTH'(1);
          read_data_a <= '0;
          read_data_b <= '0;
          if (clear_ptr == POINTER_WIDTH'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          ready       <= 1'b1;
          read_data_a <= next_a;
          read_data_b <= next_b;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w. Three instances share stimulus:
// defaults, ZERO_REG=1, and CLEAR_ON_RESET=0 (ready timing only). A small
// reference model computes expected read data when stimulus is driven; the
// expectation is queued and popped once the DUT output is valid.
module tb_register_file_2r1w;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write_enable = 1'b0;
  logic [2:0] write_address = '0;
  logic [7:0] write_data = '0;
  logic [2:0] read_address_a = '0;
  logic       is_immediate_a = 1'b0;
  logic [2:0] read_address_b = '0;

  logic [7:0] read_data_a, read_data_b;
  logic       ready;
  logic [7:0] z_read_data_a, z_read_data_b;
  logic       z_ready;
  logic [7:0] n_read_data_a, n_read_data_b;
  logic       n_ready;

  register_file_2r1w dut (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data),
    .read_address_a(read_address_a), .is_immediate_a(is_immediate_a),
    .read_address_b(read_address_b), .read_data_a(read_data_a),
    .read_data_b(read_data_b), .ready(ready)
  );

  register_file_2r1w #(.ZERO_REG(1'b1)) dut_z (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data),
    .read_address_a(read_address_a), .is_immediate_a(is_immediate_a),
    .read_address_b(read_address_b), .read_data_a(z_read_data_a),
    .read_data_b(z_read_data_b), .ready(z_ready)
  );

  register_file_2r1w #(.CLEAR_ON_RESET(1'b0)) dut_n (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data),
    .read_address_a(read_address_a), .is_immediate_a(is_immediate_a),
    .read_address_b(read_address_b), .read_data_a(n_read_data_a),
    .read_data_b(n_read_data_b), .ready(n_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] za;
    logic [7:0] zb;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [8];
  logic [7:0] zmem_m[8];
  bit         clearing = 1'b0;
  int         errors = 0;
  int         checks = 0;

  function automatic exp_t model(input logic we, input logic [2:0] wa,
                                 input logic [7:0] wd, input logic [2:0] ra,
                                 input logic imm, input logic [2:0] rb);
    exp_t r;
    r = '{a: 8'h00, b: 8'h00, za: 8'h00, zb: 8'h00};
    if (!clearing) begin
      r.a  = imm ? {5'b0, ra} : (we && wa == ra) ? wd : mem_m[ra];
      r.b  = (we && wa == rb) ? wd : mem_m[rb];
      r.za = imm ? {5'b0, ra} : (ra == 3'd0) ? 8'h00
           : (we && wa == ra) ? wd : zmem_m[ra];
      r.zb = (rb == 3'd0) ? 8'h00 : (we && wa == rb) ? wd : zmem_m[rb];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_models();
    for (int i = 0; i < 8; i++) begin
      mem_m[i]  = 8'h00;
      zmem_m[i] = 8'h00;
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, update the model and
  // advance to just after the sampling edge.
  task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] ra, input logic imm, input logic [2:0] rb);
    write_enable   = we;
    write_address  = wa;
    write_data     = wd;
    read_address_a = ra;
    is_immediate_a = imm;
    read_address_b = rb;
    sb.push_back(model(we, wa, wd, ra, imm, rb));
    if (!clearing && we) begin
      mem_m[wa] = wd;
      if (wa != 3'd0) zmem_m[wa] = wd;
    end
    tick();
    write_enable = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({read_data_a, read_data_b, ready, z_ready, n_ready} !== {8'h00, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: got a=%h b=%h ready=%b z_ready=%b n_ready=%b expected 00 00 0 0 0",
               read_data_a, read_data_b, ready, z_ready, n_ready);
    end
  endtask

  task automatic test_clear();
    exp_t e;
    reset    = 1'b0;
    clearing = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 3'd0, 8'h00, 3'(i), i[0], 3'(~i));
      e = sb.pop_front();
      checks++;
      if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {e.a, e.b, e.za, e.zb}) begin
        errors++;
        $display("FAIL clear_outputs[%0d]: got a=%h b=%h za=%h zb=%h expected a=%h b=%h za=%h zb=%h",
                 i, read_data_a, read_data_b, z_read_data_a, z_read_data_b, e.a, e.b, e.za, e.zb);
      end
      checks++;
      if ({ready, z_ready, n_ready} !== {(i == 8), (i == 8), 1'b1}) begin
        errors++;
        $display("FAIL clear_ready[edge %0d]: got ready=%b z_ready=%b n_ready=%b expected %b %b 1",
                 i, ready, z_ready, n_ready, (i == 8), (i == 8));
      end
    end
    clearing = 1'b0;
    zero_models();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 8'h00, 3'(i), 1'b0, 3'(i));
      e = sb.pop_front();
      checks++;
      if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {e.a, e.b, e.za, e.zb}) begin
        errors++;
        $display("FAIL clear_readback[%0d]: got a=%h b=%h za=%h zb=%h expected a=%h b=%h za=%h zb=%h",
                 i, read_data_a, read_data_b, z_read_data_a, z_read_data_b, e.a, e.b, e.za, e.zb);
      end
    end
  endtask

  task automatic test_fill_dual();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 8'(7 - i), 3'(i + 1), 1'b0, 3'(i + 3));
      e = sb.pop_front();
      checks++;
      if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {e.a, e.b, e.za, e.zb}) begin
        errors++;
        $display("FAIL fill_write[%0d]: got a=%h b=%h za=%h zb=%h expected a=%h b=%h za=%h zb=%h",
                 i, read_data_a, read_data_b, z_read_data_a, z_read_data_b, e.a, e.b, e.za, e.zb);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 8'h00, 3'(i), 1'b0, 3'(7 - i));
      e = sb.pop_front();
      checks++;
      if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {e.a, e.b, e.za, e.zb}) begin
        errors++;
        $display("FAIL dual_read[%0d]: got a=%h b=%h za=%h zb=%h expected a=%h b=%h za=%h zb=%h",
                 i, read_data_a, read_data_b, z_read_data_a, z_read_data_b, e.a, e.b, e.za, e.zb);
      end
      checks++;
      if ({read_data_a, read_data_b} !== {8'(7 - i), 8'(i)}) begin
        errors++;
        $display("FAIL dual_read_const[%0d]: got a=%h b=%h expected a=%h b=%h",
                 i, read_data_a, read_data_b, 8'(7 - i), 8'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    step(1'b1, 3'd3, 8'h11, 3'd0, 1'b0, 3'd1);
    void'(sb.pop_front());
    step(1'b1, 3'd3, 8'h5A, 3'd3, 1'b0, 3'd3);
    e = sb.pop_front();
    checks++;
    if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {8'h5A, 8'h5A, e.za, e.zb}) begin
      errors++;
      $display("FAIL bypass_both: got a=%h b=%h za=%h zb=%h expected a=5a b=5a za=%h zb=%h",
               read_data_a, read_data_b, z_read_data_a, z_read_data_b, e.za, e.zb);
    end
    step(1'b0, 3'd0, 8'h00, 3'd3, 1'b0, 3'd3);
    e = sb.pop_front();
    checks++;
    if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {8'h5A, 8'h5A, e.za, e.zb}) begin
      errors++;
      $display("FAIL bypass_hold: got a=%h b=%h za=%h zb=%h expected a=5a b=5a za=%h zb=%h",
               read_data_a, read_data_b, z_read_data_a, z_read_data_b, e.za, e.zb);
    end
    // Consecutive writes, each cycle reading back the previous write.
    step(1'b1, 3'd4, 8'hC4, 3'd3, 1'b0, 3'd6);
    void'(sb.pop_front());
    step(1'b1, 3'd6, 8'h36, 3'd4, 1'b0, 3'd5);
    e = sb.pop_front();
    checks++;
    if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {e.a, e.b, e.za, e.zb}) begin
      errors++;
      $display("FAIL back_to_back: got a=%h b=%h za=%h zb=%h expected a=%h b=%h za=%h zb=%h",
               read_data_a, read_data_b, z_read_data_a, z_read_data_b, e.a, e.b, e.za, e.zb);
    end
    step(1'b0, 3'd0, 8'h00, 3'd6, 1'b0, 3'd4);
    e = sb.pop_front();
    checks++;
    if ({read_data_a, read_data_b} !== {8'h36, 8'hC4} ||
        {z_read_data_a, z_read_data_b} !== {e.za, e.zb}) begin
      errors++;
      $display("FAIL back_to_back_read: got a=%h b=%h za=%h zb=%h expected a=36 b=c4 za=%h zb=%h",
               read_data_a, read_data_b, z_read_data_a, z_read_data_b, e.za, e.zb);
    end
  endtask

  task automatic test_immediate();
    exp_t e;
    step(1'b1, 3'd5, 8'hFF, 3'd5, 1'b1, 3'd5);
    e = sb.pop_front();
    checks++;
    if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {8'h05, 8'hFF, 8'h05, 8'hFF}) begin
      errors++;
      $display("FAIL immediate: got a=%h b=%h za=%h zb=%h expected a=05 b=ff za=05 zb=ff",
               read_data_a, read_data_b, z_read_data_a, z_read_data_b);
    end
    step(1'b0, 3'd0, 8'h00, 3'd7, 1'b1, 3'd5);
    e = sb.pop_front();
    checks++;
    if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {e.a, e.b, e.za, e.zb}) begin
      errors++;
      $display("FAIL immediate_7: got a=%h b=%h za=%h zb=%h expected a=%h b=%h za=%h zb=%h",
               read_data_a, read_data_b, z_read_data_a, z_read_data_b, e.a, e.b, e.za, e.zb);
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    step(1'b1, 3'd0, 8'hAA, 3'd0, 1'b0, 3'd0);
    e = sb.pop_front();
    checks++;
    if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {8'hAA, 8'hAA, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL zero_bypass: got a=%h b=%h za=%h zb=%h expected a=aa b=aa za=00 zb=00",
               read_data_a, read_data_b, z_read_data_a, z_read_data_b);
    end
    step(1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd0);
    e = sb.pop_front();
    checks++;
    if ({read_data_a, z_read_data_a, z_read_data_b} !== {8'hAA, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL zero_read: got a=%h za=%h zb=%h expected a=aa za=00 zb=00",
               read_data_a, z_read_data_a, z_read_data_b);
    end
    step(1'b1, 3'd1, 8'hAA, 3'd2, 1'b0, 3'd1);
    e = sb.pop_front();
    step(1'b0, 3'd0, 8'h00, 3'd1, 1'b0, 3'd1);
    e = sb.pop_front();
    checks++;
    if ({z_read_data_a, z_read_data_b, read_data_a} !== {8'hAA, 8'hAA, e.a}) begin
      errors++;
      $display("FAIL zero_reg1: got za=%h zb=%h a=%h expected za=aa zb=aa a=%h",
               z_read_data_a, z_read_data_b, read_data_a, e.a);
    end
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    reset = 1'b1;
    tick();
    checks++;
    if ({ready, z_ready, n_ready} !== 3'b000) begin
      errors++;
      $display("FAIL run_reset_ready: got ready=%b z_ready=%b n_ready=%b expected 0 0 0",
               ready, z_ready, n_ready);
    end
    reset    = 1'b0;
    clearing = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 3'(i + 3), 8'hEE, 3'(i + 3), 1'b0, 3'(i + 3));
      e = sb.pop_front();
      checks++;
      if ({read_data_a, read_data_b, ready, z_ready, n_ready} !== {e.a, e.b, 3'b001}) begin
        errors++;
        $display("FAIL partial_clear[%0d]: got a=%h b=%h ready=%b z_ready=%b n_ready=%b expected 00 00 0 0 1",
                 i, read_data_a, read_data_b, ready, z_ready, n_ready);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 3'(i), 8'hEE, 3'(i), 1'b0, 3'(i));
      e = sb.pop_front();
      checks++;
      if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {e.a, e.b, e.za, e.zb} ||
          {ready, z_ready} !== {(i == 8), (i == 8)}) begin
        errors++;
        $display("FAIL restart_clear[edge %0d]: got a=%h b=%h ready=%b z_ready=%b expected 00 00 %b %b",
                 i, read_data_a, read_data_b, ready, z_ready, (i == 8), (i == 8));
      end
    end
    clearing = 1'b0;
    zero_models();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 8'h00, 3'(i), 1'b0, 3'(7 - i));
      e = sb.pop_front();
      checks++;
      if ({read_data_a, read_data_b, z_read_data_a, z_read_data_b} !== {e.a, e.b, e.za, e.zb}) begin
        errors++;
        $display("FAIL after_restart[%0d]: got a=%h b=%h za=%h zb=%h expected a=%h b=%h za=%h zb=%h",
                 i, read_data_a, read_data_b, z_read_data_a, z_read_data_b, e.a, e.b, e.za, e.zb);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    zero_models();
    test_reset();
    test_clear();
    test_fill_dual();
    test_back_to_back();
    test_immediate();
    test_zero_reg();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
